// File: rtl/clock12_ampm_scan.sv
// 12-hour HH:MM:SS AM/PM timekeeper with a registered 4-digit multiplexed display driver.
// Time is stored as BCD digit pairs so that display codes come straight from the registers.
module clock12_ampm_scan #(
  parameter int ONE_SEC_CYCLES = 40_000_000,
  parameter int SCAN_CYCLES    = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       mode,
  input  logic       hr_inc,
  input  logic       min_inc,
  output logic [3:0] bcd,
  output logic [3:0] ftsd_ctl,
  output logic       sec_tick,
  output logic       pm
);

  localparam int PW = (ONE_SEC_CYCLES > 1) ? $clog2(ONE_SEC_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(ONE_SEC_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);

  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic [2:0]    r_sec_t;
  logic [3:0]    r_sec_o;
  logic [2:0]    r_min_t;
  logic [3:0]    r_min_o;
  logic          r_hr_t;
  logic [3:0]    r_hr_o;
  logic          r_pm;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_bcd;
  logic [3:0]    r_ftsd;

  logic       w_sec_wrap;
  logic       w_min_step;
  logic       w_hr_carry;
  logic       w_hr_step;
  logic       w_hr_is11;
  logic       w_hr_is12;
  logic [3:0] w_code;
  logic [3:0] w_sel;

  // A manual minute step swallows the carry so the minute moves exactly once
  // and the hour is not dragged along by the wrap.
  assign w_sec_wrap = r_sec_tick && (r_sec_t == 3'd5) && (r_sec_o == 4'd9);
  assign w_min_step = min_inc || w_sec_wrap;
  assign w_hr_carry = w_sec_wrap && !min_inc && (r_min_t == 3'd5) && (r_min_o == 4'd9);
  assign w_hr_step  = hr_inc || w_hr_carry;
  assign w_hr_is11  = r_hr_t && (r_hr_o == 4'd1);
  assign w_hr_is12  = r_hr_t && (r_hr_o == 4'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
    end else if (run_en) begin
      if (r_presc == PRESC_LAST) begin
        r_presc    <= '0;
        r_sec_tick <= 1'b1;
      end else begin
        r_presc    <= r_presc + PW'(1);
        r_sec_tick <= 1'b0;
      end
    end else begin
      r_sec_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_t <= 3'd0;
      r_sec_o <= 4'd0;
    end else if (r_sec_tick) begin
      if (r_sec_o == 4'd9) begin
        r_sec_o <= 4'd0;
        r_sec_t <= (r_sec_t == 3'd5) ? 3'd0 : r_sec_t + 3'd1;
      end else begin
        r_sec_o <= r_sec_o + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_t <= 3'd0;
      r_min_o <= 4'd0;
    end else if (w_min_step) begin
      if (r_min_o == 4'd9) begin
        r_min_o <= 4'd0;
        r_min_t <= (r_min_t == 3'd5) ? 3'd0 : r_min_t + 3'd1;
      end else begin
        r_min_o <= r_min_o + 4'd1;
      end
    end
  end

  // Hours run 12,1..11,12; the AM/PM flag flips only on entering 12.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hr_t <= 1'b1;
      r_hr_o <= 4'd2;
      r_pm   <= 1'b0;
    end else if (w_hr_step) begin
      if (w_hr_is11) begin
        r_pm <= ~r_pm;
      end
      if (w_hr_is12) begin
        r_hr_t <= 1'b0;
        r_hr_o <= 4'd1;
      end else if (r_hr_o == 4'd9) begin
        r_hr_t <= 1'b1;
        r_hr_o <= 4'd0;
      end else begin
        r_hr_o <= r_hr_o + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  always_comb begin
    w_code = 4'd15;
    if (!mode) begin
      case (r_idx)
        2'd3:    w_code = r_hr_t ? 4'd1 : 4'd15;
        2'd2:    w_code = r_hr_o;
        2'd1:    w_code = {1'b0, r_min_t};
        default: w_code = r_min_o;
      endcase
    end else begin
      case (r_idx)
        2'd3:    w_code = r_pm ? 4'd12 : 4'd10;
        2'd2:    w_code = 4'd11;
        2'd1:    w_code = {1'b0, r_sec_t};
        default: w_code = r_sec_o;
      endcase
    end
  end

  assign w_sel = ~(4'b0001 << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= 4'd0;
      r_ftsd <= 4'b1110;
    end else begin
      r_bcd  <= w_code;
      r_ftsd <= w_sel;
    end
  end

  assign bcd      = r_bcd;
  assign ftsd_ctl = r_ftsd;
  assign sec_tick = r_sec_tick;
  assign pm       = r_pm;

endmodule

// File: tb/tb_clock12_ampm_scan.sv
// Bench for clock12_ampm_scan: integer time-of-day model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_clock12_ampm_scan;
  localparam int OSC = 4;
  localparam int SC  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic       mode = 1'b0;
  logic       hr_inc = 1'b0;
  logic       min_inc = 1'b0;
  logic [3:0] bcd;
  logic [3:0] ftsd_ctl;
  logic       sec_tick;
  logic       pm;

  int vectors = 0;
  int miscompares = 0;
  int ticks_seen = 0;

  int m_h, m_m, m_s, m_presc, m_scan, m_idx;
  bit m_pm, m_tick;
  logic [3:0] m_bcd, m_ftsd;
  logic [3:0] disp [4];

  logic [3:0] t1_f [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] t1_b [4] = '{4'd0, 4'd0, 4'd2, 4'd1};

  always #5 clk = ~clk;

  clock12_ampm_scan #(.ONE_SEC_CYCLES(OSC), .SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .mode(mode),
    .hr_inc(hr_inc), .min_inc(min_inc),
    .bcd(bcd), .ftsd_ctl(ftsd_ctl), .sec_tick(sec_tick), .pm(pm)
  );

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] digit_of(input int idx, input bit md, input int h,
                                          input int mi, input int s, input bit p);
    if (!md) begin
      case (idx)
        3:       return (h >= 10) ? 4'd1 : 4'd15;
        2:       return 4'(h % 10);
        1:       return 4'(mi / 10);
        default: return 4'(mi % 10);
      endcase
    end
    case (idx)
      3:       return p ? 4'd12 : 4'd10;
      2:       return 4'd11;
      1:       return 4'(s / 10);
      default: return 4'(s % 10);
    endcase
  endfunction

  task automatic model_reset();
    m_h = 12; m_m = 0; m_s = 0; m_pm = 0;
    m_presc = 0; m_tick = 0; m_scan = 0; m_idx = 0;
    m_bcd = 4'd0; m_ftsd = 4'b1110;
  endtask

  // Advance the model by one rising edge, using inputs held since the previous negedge.
  task automatic model_step();
    bit s_wrap, h_carry;
    m_bcd  = digit_of(m_idx, mode, m_h, m_m, m_s, m_pm);
    m_ftsd = 4'b1111;
    m_ftsd[m_idx] = 1'b0;
    s_wrap  = m_tick && (m_s == 59);
    h_carry = s_wrap && !min_inc && (m_m == 59);
    if (m_tick) m_s = (m_s + 1) % 60;
    if (s_wrap || min_inc) m_m = (m_m + 1) % 60;
    if (hr_inc || h_carry) begin
      if (m_h == 11) m_pm = !m_pm;
      m_h = m_h % 12 + 1;
    end
    if (run_en) begin
      if (m_presc == OSC - 1) begin m_presc = 0; m_tick = 1; end
      else begin m_presc++; m_tick = 0; end
    end else begin
      m_tick = 0;
    end
    if (m_scan == SC - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
    else m_scan++;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      model_step();
      chk("bcd", bcd, m_bcd);
      chk("ftsd_ctl", ftsd_ctl, m_ftsd);
      chk("sec_tick", sec_tick, m_tick);
      chk("pm", pm, m_pm);
      if (sec_tick) ticks_seen++;
    end
  endtask

  // Called right after a negedge: reset lands between edges.
  task automatic apply_reset(input bit check_now);
    #2 rst = 1'b1;
    #1;
    if (check_now) begin
      chk("async_rst_bcd", bcd, 0);
      chk("async_rst_ftsd", ftsd_ctl, 4'b1110);
      chk("async_rst_tick", sec_tick, 0);
      chk("async_rst_pm", pm, 0);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic show(input bit md);
    mode = md;
    for (int i = 0; i < 4; i++) disp[i] = 4'd14;
    repeat (2) cycle();
    repeat (8) begin
      cycle();
      case (ftsd_ctl)
        4'b1110: disp[0] = bcd;
        4'b1101: disp[1] = bcd;
        4'b1011: disp[2] = bcd;
        4'b0111: disp[3] = bcd;
        default: ;
      endcase
    end
  endtask

  task automatic run_until_s(input int target, input int bound);
    int n = 0;
    run_en = 1'b1;
    while (m_s != target && n < bound) begin cycle(); n++; end
    run_en = 1'b0;
    if (m_s != target) chk("run_timeout", m_s, target);
  endtask

  task automatic pulse_hr_to(input int h);
    int n = 0;
    while (m_h != h && n < 24) begin
      hr_inc = 1'b1; cycle(); hr_inc = 1'b0; cycle(); n++;
    end
    if (m_h != h) chk("hr_preset_timeout", m_h, h);
  endtask

  task automatic pulse_min_to(input int mi);
    int n = 0;
    while (m_m != mi && n < 120) begin
      min_inc = 1'b1; cycle(); min_inc = 1'b0; cycle(); n++;
    end
    if (m_m != mi) chk("min_preset_timeout", m_m, mi);
  endtask

  initial begin
    int n;
    model_reset();
    #12 rst = 1'b0;

    // Scan rotation from reset, mode 0.
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t1_ftsd", ftsd_ctl, t1_f[k/2]);
      chk("t1_bcd", bcd, t1_b[k/2]);
    end

    // 60 seconds of running from reset.
    apply_reset(1'b0);
    run_en = 1'b1;
    ticks_seen = 0;
    repeat (240) cycle();
    chk("t2_tick_count", ticks_seen, 60);
    run_en = 1'b0;
    cycle();
    chk("t2_model_h", m_h, 12); chk("t2_model_m", m_m, 1); chk("t2_model_s", m_s, 0);
    show(1'b1);
    chk("t2_sec_ones", disp[0], 0); chk("t2_sec_tens", disp[1], 0);
    chk("t2_m", disp[2], 11); chk("t2_am", disp[3], 10);
    show(1'b0);
    chk("t2_d3", disp[3], 1); chk("t2_d2", disp[2], 2);
    chk("t2_d1", disp[1], 0); chk("t2_d0", disp[0], 1);

    // 11:59:59 AM -> 12:00:00 PM.
    pulse_hr_to(11);
    pulse_min_to(59);
    run_until_s(59, 300);
    chk("t3_pm_before", pm, 0);
    run_until_s(0, 20);
    cycle();
    chk("t3_pm_after", pm, 1);
    show(1'b1);
    chk("t3_pm_code", disp[3], 12); chk("t3_m_code", disp[2], 11);
    chk("t3_s1", disp[1], 0); chk("t3_s0", disp[0], 0);
    show(1'b0);
    chk("t3_h1", disp[3], 1); chk("t3_h0", disp[2], 2);
    chk("t3_m1", disp[1], 0); chk("t3_m0", disp[0], 0);

    // 12:59:59 PM -> 1:00:00 PM.
    pulse_min_to(59);
    run_until_s(59, 300);
    run_until_s(0, 20);
    cycle();
    chk("t4_pm_kept", pm, 1);
    show(1'b0);
    chk("t4_blank", disp[3], 15); chk("t4_h0", disp[2], 1);
    chk("t4_m1", disp[1], 0); chk("t4_m0", disp[0], 0);

    // 03:05:59 with min_inc coinciding with sec_tick.
    pulse_hr_to(3);
    pulse_min_to(5);
    run_until_s(59, 300);
    run_en = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!sec_tick && n < 10);
    chk("t5_tick_seen", sec_tick, 1);
    min_inc = 1'b1; run_en = 1'b0;
    cycle();
    min_inc = 1'b0;
    cycle();
    show(1'b0);
    chk("t5_h0", disp[2], 3); chk("t5_m1", disp[1], 0); chk("t5_m0", disp[0], 6);
    show(1'b1);
    chk("t5_s1", disp[1], 0); chk("t5_s0", disp[0], 0);
    hr_inc = 1'b1; cycle(); hr_inc = 1'b0;
    repeat (20) cycle();
    show(1'b0);
    chk("t5_h_run_off", disp[2], 4); chk("t5_m0_held", disp[0], 6);
    show(1'b1);
    chk("t5_s0_held", disp[0], 0); chk("t5_s1_held", disp[1], 0);

    // Async reset mid-count.
    run_en = 1'b1;
    repeat (7) cycle();
    apply_reset(1'b1);
    repeat (8) cycle();
    chk("t6_model_h", m_h, 12);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      run_en  = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) mode = !mode;
      hr_inc  = ($urandom % 32) == 0;
      min_inc = ($urandom % 16) == 0;
      if ($urandom % 1000 == 0) begin
        hr_inc = 1'b0; min_inc = 1'b0;
        apply_reset(1'b1);
      end
      cycle();
    end
    hr_inc = 1'b0; min_inc = 1'b0; run_en = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
